pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised, elastic successor to the fixed EX/MEM latch. It is a 2-entry skid-buffered
//  pipeline register with a valid/ready handshake, so a downstream stall (e.g. cache miss)
//  back-pressures upstream without a combinational ready path. Flush inserts a NOP bubble.
//  A saturating stall counter is included for performance debug.
//  Instantiated between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
// PARAMETERS
//  DATA_W      102  payload bits (ALU result, branch target, store data, rd, zero flag)
//  CTRL_W      5    control bits (mem_to_reg, reg_write, mem_read, mem_write, branch)
//  CLR_DATA    0    1: flush/reset also zeroes the data registers; 0: only ctrl is zeroed
//  CNT_W       16   stall counter width
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous reset, active-low
//  flush       in   1        synchronous kill of all held and incoming entries
//  in_valid    in   1        upstream entry valid
//  in_ready    out  1        buffer accepts this cycle (registered, state != FULL)
//  in_data     in   DATA_W   upstream payload
//  in_ctrl     in   CTRL_W   upstream control bits
//  out_valid   out  1        head entry valid
//  out_ready   in   1        downstream accepts the head entry
//  out_data    out  DATA_W   head payload
//  out_ctrl    out  CTRL_W   head control; all-zero whenever out_valid=0 (NOP)
//  stall_cnt   out  CNT_W    cycles with out_valid & !out_ready, saturating
//  stall_clr   in   1        synchronous clear of stall_cnt
// BEHAVIOUR
//  - Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - in_ready is a function of state registers only. It has no path from out_ready.
//  - Registers: main entry (drives outputs), skid entry, and a 2-bit state.
//  - State encoding: EMPTY=0, ONE=1, FULL=2.
//    - EMPTY: in_fire -> ONE, main<=in.
//    - ONE:   in_fire & !out_fire -> FULL, skid<=in.
//             out_fire & !in_fire -> EMPTY, main ctrl<=0.
//             in_fire & out_fire  -> ONE, main<=in.
//    - FULL:  in_ready=0. out_fire -> ONE, main<=skid, skid ctrl<=0.
//    - State encoding 3 is illegal: treat as EMPTY on the next edge.
//  - Latency: 1 cycle, in_fire at edge N gives out_valid after edge N.
//  - Throughput: 1 entry/cycle while out_ready=1. No entry is dropped or duplicated.
//  - out_valid = (state != EMPTY). out_data/out_ctrl always reflect the main entry.
//  - Flush has top priority over all handshakes:
//    - Next state is EMPTY.
//    - Main and skid ctrl are zeroed. Data is zeroed only if CLR_DATA=1.
//    - The in_data offered in the same cycle is discarded, even if in_valid=1.
//    - in_ready stays at its registered value during the flush cycle. Upstream must treat
//      the flush cycle as consumed.
//  - Reset (async, any time, including mid-transfer):
//    - state=EMPTY, out_valid=0, in_ready=1, out_ctrl=0, stall_cnt=0.
//    - out_data=0 and skid=0 regardless of CLR_DATA.
//  - stall_cnt:
//    - Increments when out_valid & !out_ready and not flush.
//    - Holds at 2^CNT_W-1.
//    - stall_clr has priority over increment and forces 0.
//  - Width rules: no arithmetic on the payload. stall_cnt increment is CNT_W-bit unsigned
//    with explicit saturation compare.
// STRUCTURE
//  - Shared header pipe_defs.vh: state localparams ST_EMPTY/ST_ONE/ST_FULL, the
//    PIPE_CTRL_W default, and ctrl bit indices (CTRL_MEM2REG=0 ... CTRL_BRANCH=4).
//  - One sub-module, pipe_skid_ctrl: state FSM producing in_ready, out_valid, load_main,
//    load_skid, main_from_skid and clr_ctrl strobes.
//  - The datapath registers and stall_cnt stay in the top module.
// TESTING
//  1. Reset then stream:
//     - rst_n low 3 cycles, then in_valid=1 with data=1,2,3,4 and out_ready=1.
//     - Expect in_ready=1 throughout. out_data=1,2,3,4 one cycle later, back-to-back.
//     - stall_cnt stays 0.
//  2. Back-pressure:
//     - Send 0xA, 0xB with out_ready=0.
//     - Expect state FULL, in_ready=0, 0xC held upstream.
//     - Raise out_ready: outputs A, B, C in order, no loss.
//     - Expect stall_cnt = number of stalled cycles (e.g. 3).
//  3. Flush while FULL:
//     - Assert flush with in_valid=1, data=0xD.
//     - Next cycle: out_valid=0, out_ctrl=0, in_ready=1.
//     - 0xD never appears at out_data.
//     - With CLR_DATA=1, out_data=0.
//  4. Simultaneous in_fire/out_fire in ONE:
//     - Alternate out_ready 1/0 every cycle with continuous input 0x10..0x1F.
//     - Output order is preserved and in_ready never drops while occupancy is below 2.
//  5. Counter saturation:
//     - CNT_W=4, out_valid held with out_ready=0 for 20 cycles.
//     - stall_cnt stops at 15.
//     - stall_clr and a stall in the same cycle -> 0.
//  6. Async reset mid-transfer:
//     - Drop rst_n between clock edges while FULL.
//     - Outputs go to reset values immediately (before the next edge).
//     - Resume cleanly after release.

Source files
------------

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding, default
// control width and control-bit positions.
package pipe_stage_elastic_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_e;

   localparam int PIPE_CTRL_W = 5;

   typedef enum int {
      CTRL_MEM2REG   = 0,
      CTRL_REG_WRITE = 1,
      CTRL_MEM_READ  = 2,
      CTRL_MEM_WRITE = 3,
      CTRL_BRANCH    = 4
   } ctrl_bit_e;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy FSM for the 2-entry skid buffer. Produces the handshake outputs and
// the load strobes that steer the datapath registers in the top module.
module pipe_skid_ctrl
   import pipe_stage_elastic_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic in_valid,
   input  logic out_ready,
   output logic in_ready,
   output logic out_valid,
   output logic load_main,
   output logic load_skid,
   output logic main_from_skid,
   output logic clr_ctrl
);

   pipe_state_e state_q, state_d;
   logic        in_fire, out_fire;

   // Both handshake outputs decode the state register only, so in_ready never
   // sees out_ready combinationally.
   assign in_ready  = (state_q != ST_FULL);
   assign out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      clr_ctrl       = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (in_fire) begin
               state_d   = ST_ONE;
               load_main = 1'b1;
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  load_main = 1'b1;
               end else if (in_fire) begin
                  state_d   = ST_FULL;
                  load_skid = 1'b1;
               end else if (out_fire) begin
                  state_d  = ST_EMPTY;
                  clr_ctrl = 1'b1;
               end
            end
            ST_FULL: if (out_fire) begin
               state_d        = ST_ONE;
               main_from_skid = 1'b1;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic 2-entry skid-buffered pipeline register with flush-to-NOP and a
// saturating stall counter for performance debug.
module pipe_stage_elastic
   import pipe_stage_elastic_pkg::*;
#(
   parameter int DATA_W   = 102,
   parameter int CTRL_W   = PIPE_CTRL_W,
   parameter bit CLR_DATA = 1'b0,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DATA_W-1:0] main_data, skid_data;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic              load_main, load_skid, main_from_skid, clr_ctrl;

   pipe_skid_ctrl u_ctrl (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .out_ready     (out_ready),
      .in_ready      (in_ready),
      .out_valid     (out_valid),
      .load_main     (load_main),
      .load_skid     (load_skid),
      .main_from_skid(main_from_skid),
      .clr_ctrl      (clr_ctrl)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_data <= '0;
         main_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
      end else if (flush) begin
         main_ctrl <= '0;
         skid_ctrl <= '0;
         if (CLR_DATA) begin
            main_data <= '0;
            skid_data <= '0;
         end
      end else begin
         if (load_main) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
         end else if (main_from_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
         end else if (clr_ctrl) begin
            main_ctrl <= '0;
         end
         if (load_skid) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
         end else if (main_from_skid) begin
            skid_ctrl <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (stall_clr)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && !flush && (stall_cnt != CNT_MAX))
         stall_cnt <= stall_cnt + 1'b1;
   end

   assign out_data = main_data;
   // Gate keeps a bubble a guaranteed NOP even if main ctrl were ever stale.
   assign out_ctrl = out_valid ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench: a capacity-2 FIFO model predicts every output at each negedge.
module tb_pipe_stage_elastic;

   localparam int DW = 102;
   localparam int CW = 5;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, stall_clr;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [NW-1:0] stall_cnt;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } ent_t;

   ent_t          q[$];
   logic [DW-1:0] idle_data;
   int            exp_cnt;
   int            tests = 0;
   int            fails = 0;

   pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CLR_DATA(1'b1), .CNT_W(NW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
      return d[CW-1:0] ^ 5'h13;
   endfunction

   // Model: the stage behaves as a FIFO of depth 2; the head is the output.
   initial begin
      ent_t e;
      bit   in_f, out_f;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            idle_data = '0;
            exp_cnt   = 0;
         end
         chk("out_valid", out_valid, q.size() != 0);
         chk("in_ready", in_ready, q.size() < 2);
         chk("stall_cnt", stall_cnt, exp_cnt);
         if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_ctrl", out_ctrl, q[0].c);
         end else begin
            chk("nop_ctrl", out_ctrl, '0);
            chk("idle_data", out_data, idle_data);
         end
         if (rst_n) begin
            in_f  = in_valid && (q.size() < 2);
            out_f = (q.size() != 0) && out_ready;
            if (stall_clr) exp_cnt = 0;
            else if (q.size() != 0 && !out_ready && !flush && exp_cnt < (1 << NW) - 1) exp_cnt++;
            if (flush) begin
               q.delete();
               idle_data = '0;
            end else begin
               if (out_f) begin
                  e = q.pop_front();
                  if (q.size() == 0 && !in_f) idle_data = e.d;
               end
               if (in_f) q.push_back({in_data, in_ctrl});
            end
         end
      end
   end

   task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy,
                      input logic fl = 1'b0, input logic clr = 1'b0);
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = ctrl_of(d);
      out_ready = ordy;
      flush     = fl;
      stall_clr = clr;
      @(posedge clk);
      #1;
   endtask

   // Upstream holds the entry until it is accepted; alt toggles out_ready each cycle.
   task automatic send(input logic [DW-1:0] d, input bit alt);
      bit fired = 1'b0;
      int n = 0;
      while (!fired && n < 50) begin
         if (alt) out_ready = ~out_ready;
         fired = in_ready;
         cyc(1'b1, d, out_ready);
         n++;
      end
      if (!fired) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: got no accept expected accept for %0h", d);
      end
   endtask

   initial begin
      logic [127:0] r;
      rst_n = 1'b1; flush = 0; in_valid = 0; out_ready = 0; stall_clr = 0;
      in_data = '0; in_ctrl = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // stream 1..4 at full rate
      for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(i), 1'b1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);

      // back-pressure: A, B fill the buffer, C waits upstream
      cyc(1'b1, DW'('hA), 1'b0);
      cyc(1'b1, DW'('hB), 1'b0);
      cyc(1'b1, DW'('hC), 1'b0);
      cyc(1'b1, DW'('hC), 1'b1);
      cyc(1'b1, DW'('hC), 1'b1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      chk("bp_stall_cnt", stall_cnt, 2);

      // flush while full, with a live offer that must be discarded
      cyc(1'b1, DW'(1), 1'b0);
      cyc(1'b1, DW'(2), 1'b0);
      cyc(1'b1, DW'('hD), 1'b0, 1'b1);
      chk("flush_valid", out_valid, 0);
      chk("flush_data", out_data, 0);
      cyc(1'b0, '0, 1'b1);

      // alternating out_ready with continuous input
      out_ready = 1'b0;
      for (int i = 'h10; i <= 'h1F; i++) send(DW'(i), 1'b1);
      repeat (3) cyc(1'b0, '0, 1'b1);

      // counter saturation, then clear racing a stall
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
      cyc(1'b1, DW'('h55), 1'b0);
      repeat (20) cyc(1'b0, '0, 1'b0);
      chk("sat_cnt", stall_cnt, 15);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("clr_over_inc", stall_cnt, 0);
      cyc(1'b0, '0, 1'b1);

      // async reset between edges while full
      cyc(1'b1, DW'('h61), 1'b0);
      cyc(1'b1, DW'('h62), 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_ready", in_ready, 1);
      chk("arst_ctrl", out_ctrl, 0);
      chk("arst_data", out_data, 0);
      chk("arst_cnt", stall_cnt, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 'h70; i <= 'h73; i++) cyc(1'b1, DW'(i), 1'b1);
      cyc(1'b0, '0, 1'b1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         r = {$urandom, $urandom, $urandom, $urandom};
         cyc(1'($urandom_range(0, 1)), r[DW-1:0], ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0));
      end
      repeat (3) cyc(1'b0, '0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
